tc_seq_mul: RTL and testbench



---
 rtl/tc_seq_mul.sv | 87 ++++++++
 tb/tb_tc_seq_mul.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tc_seq_mul.sv
// tc_seq_mul: sequential shift-add unsigned multiplier.
// One partial-product step per clock; the product is presented with a one-cycle DONE strobe.
module tc_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic               C,
   input  logic               R,
   input  logic               START,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               BUSY,
   output logic               DONE,
   output logic [2*WIDTH-1:0] P
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mc;    // multiplicand
   logic [WIDTH-1:0] mq;    // multiplier, shifts out to become the low product half
   logic [WIDTH:0]   acc;   // upper partial sum; bit WIDTH is always zero between steps
   logic [WIDTH:0]   sum;
   logic [CW-1:0]    cnt;

   // Because acc[WIDTH] is held at zero, adding the full acc equals adding its low WIDTH bits.
   assign sum  = acc + (mq[0] ? {1'b0, mc} : '0);
   assign BUSY = (state == S_RUN) || (state == S_FIN);

   // State register with synchronous reset.
   always_ff @(posedge C) begin
      if (R) state <= S_IDLE;
      else   state <= state_nxt;
   end

   // Next-state logic: IDLE -> RUN on START, RUN for WIDTH steps, then one FIN cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (START) state_nxt = S_RUN;
         S_RUN:   if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, shift-add steps, and product/strobe publication.
   always_ff @(posedge C) begin
      if (R) begin
         mc   <= '0;
         mq   <= '0;
         acc  <= '0;
         cnt  <= '0;
         P    <= '0;
         DONE <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  mc  <= A;
                  mq  <= B;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            S_RUN: begin
               // {acc,mq} <= {sum,mq} >> 1 : the carry lands in acc[WIDTH-1], acc[WIDTH] clears.
               acc <= {1'b0, sum[WIDTH:1]};
               mq  <= {sum[0], mq[WIDTH-1:1]};
               cnt <= cnt + CW'(1);
            end
            S_FIN: begin
               P    <= {acc[WIDTH-1:0], mq};
               DONE <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tc_seq_mul.sv
// Testbench for tc_seq_mul: directed scenarios at WIDTH=8 plus random sweeps at WIDTH=8 and WIDTH=3.
module tb_tc_seq_mul;

   logic        C = 1'b0;
   logic        R = 1'b0;
   logic        start8 = 1'b0, start3 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [2:0]  a3 = '0, b3 = '0;
   logic        busy8, done8, busy3, done3;
   logic [15:0] p8;
   logic [5:0]  p3;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   tc_seq_mul #(.WIDTH(8)) dut8 (
      .C(C), .R(R), .START(start8), .A(a8), .B(b8),
      .BUSY(busy8), .DONE(done8), .P(p8)
   );

   tc_seq_mul #(.WIDTH(3)) dut3 (
      .C(C), .R(R), .START(start3), .A(a3), .B(b3),
      .BUSY(busy3), .DONE(done3), .P(p3)
   );

   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation: latency and product come from A*B and WIDTH+1.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
      int n;
      a8 = a; b8 = b; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check({tag, " busy_after_accept"}, busy8, 1);
      n = 0;
      while (!done8 && n < 40) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 9);
      check({tag, " product"}, p8, 32'(a) * 32'(b));
      check({tag, " busy_in_done"}, busy8, 0);
   endtask

   // One WIDTH=3 operation.
   task automatic op3(input logic [2:0] a, input logic [2:0] b, input string tag);
      int n;
      a3 = a; b3 = b; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      n = 0;
      while (!done3 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 4);
      check({tag, " product"}, p3, 32'(a) * 32'(b));
   endtask

   initial begin
      int dones;
      // Reset state.
      R = 1'b1;
      tick();
      R = 1'b0;
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset p8", p8, 0);
      check("reset busy3", busy3, 0);
      check("reset p3", p3, 0);

      // 13*11, cycle by cycle: BUSY for WIDTH+1 cycles, then DONE with BUSY low.
      a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("basic busy c%0d", i), busy8, 1);
         check($sformatf("basic done c%0d", i), done8, 0);
         tick();
      end
      check("basic done", done8, 1);
      check("basic busy_in_done", busy8, 0);
      check("basic p", p8, 143);
      tick(); tick(); tick();
      check("basic done_once", done8, 0);
      check("basic p_holds", p8, 143);

      // Boundary operands.
      op8(8'hFF, 8'hFF, "ffxff");
      op8(8'h00, 8'hA5, "0xa5");
      op8(8'h80, 8'h02, "80x02");

      // Operand churn and STARTs during RUN and FIN are ignored.
      a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
      tick();
      for (int i = 1; i <= 9; i++) begin
         start8 = (i == 3 || i == 9);
         a8 = 8'($urandom); b8 = 8'($urandom);
         tick();
      end
      start8 = 1'b0;
      check("ignore done", done8, 1);
      check("ignore p", p8, 20000);
      tick();
      check("ignore fin_start busy", busy8, 0);
      check("ignore fin_start done", done8, 0);

      // START held: one product every WIDTH+2 cycles, BUSY low only with DONE.
      a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         check($sformatf("held done c%0d", c), done8, (c % 10) == 9);
         check($sformatf("held busy c%0d", c), busy8, (c % 10) != 9);
         if (c % 10 == 9) check($sformatf("held p c%0d", c), p8, 63);
      end
      start8 = 1'b0;
      tick();

      // Reset mid-operation takes priority over START and suppresses DONE.
      a8 = 8'd50; b8 = 8'd60; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      R = 1'b1; start8 = 1'b1;
      tick();
      R = 1'b0; start8 = 1'b0;
      check("abort busy", busy8, 0);
      check("abort done", done8, 0);
      check("abort p", p8, 0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done8) dones++;
      end
      check("abort no_done", dones, 0);
      op8(8'd5, 8'd6, "after_abort");

      // Random sweeps against a*b.
      for (int i = 0; i < 1000; i++)
         op8(8'($urandom), 8'($urandom), $sformatf("rnd8 #%0d", i));
      for (int i = 0; i < 1000; i++)
         op3(3'($urandom), 3'($urandom), $sformatf("rnd3 #%0d", i));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
